bus_copy_master: RTL and testbench
==================================

# bus_copy_master

Word-copy DMA initiator for the enable/rw/ready memory bus. Given source, destination and word count, it reads each word from the source, then writes it to the destination. Every access is one bus transaction: it holds the request until the responder raises ready, then drops enable for one cycle. It sits between a control register block and any memory responder on this bus, such as the wait-state SRAM model, and is the initiator end of that handshake.

## Interface
- TIMEOUT, 255, consecutive cycles without ready before an access is aborted; 0 disables the timeout
- COUNT_WIDTH, 16, width of the word-count input and internal remaining counter
- i_clock  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_src  in  32  source byte address; bits [1:0] ignored
- i_dst  in  32  destination byte address; bits [1:0] ignored
- i_count  in  COUNT_WIDTH  number of 32-bit words to copy
- o_busy  out  1  high from start edge until completion
- o_done  out  1  one-cycle pulse at completion or abort
- o_error  out  1  set on timeout abort; cleared by next accepted start
- o_bus_enable  out  1  request active
- o_bus_rw  out  1  0 = read, 1 = write
- o_bus_address  out  32  word-aligned byte address, bits [1:0] = 0
- o_bus_wdata  out  32  write data
- i_bus_rdata  in  32  read data; valid in the cycle i_bus_ready is sampled high on a read
- i_bus_ready  in  1  responder completion; held high by the responder until enable drops

## Operation
- States: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE:
  - enable = 0.
  - On i_start, latch src/dst (bits [1:0] cleared) and count, clear o_error, set busy.
  - If count == 0: pulse done, clear busy, stay IDLE; no bus activity.
  - Otherwise drive enable = 1, rw = 0, address = src pointer, and go to RD.
- RD:
  - Request is held stable.
  - On ready = 1: latch i_bus_rdata into a data register, enable <= 0, go to RD_GAP.
- RD_GAP: one cycle; ready is ignored. Then enable <= 1, rw <= 1, address = dst pointer, wdata = data register, go to WR.
- WR: on ready = 1: enable <= 0, remaining −1, src +4, dst +4, go to WR_GAP.
- WR_GAP:
  - Ready is ignored.
  - If remaining == 0: o_done <= 1, busy <= 0, go to IDLE.
  - Else issue the read for the next word (as in IDLE) and go to RD.
- Gap rules:
  - A gap cycle always separates two transactions, so the responder sees enable low and resets its wait counter.
  - Ready is sampled only in RD/WR.
- Pointer arithmetic: 32-bit, wraps modulo 2^32 silently. remaining is COUNT_WIDTH bits, so the maximum transfer is 2^COUNT_WIDTH − 1 words.
- Timeout:
  - A counter clears on entry to RD/WR and increments on each edge in RD/WR with ready = 0.
  - When it reaches TIMEOUT (TIMEOUT ≠ 0): enable <= 0, o_error <= 1, o_done pulse, busy <= 0, go to IDLE. Pointers and remaining are frozen.
- i_start while busy is ignored. Simultaneous i_start and completion: the start is ignored that cycle.
- i_reset has priority over everything. If asserted mid-transfer, the next edge applies reset values and the transfer is discarded.
- Reset values: state IDLE; o_busy, o_done, o_error, o_bus_enable, o_bus_rw = 0; o_bus_address, o_bus_wdata, pointers, remaining, timeout counter = 0.
- o_bus_address, o_bus_rw and o_bus_wdata change only when enable is being raised.

## Timing
- All outputs are registered.
- Let edge s be the edge accepting i_start. Enable is high from s.
- Let K be the number of edges, counting from enable rising, until the master samples ready = 1.
- Per word:
  - read complete at s+K
  - gap
  - write enable at s+K+1
  - write complete at s+2K+1
  - gap ends at s+2K+2
- N words: o_done is high in the cycle after edge s+2N(K+1). o_busy falls at that same edge.
- With the wait-state SRAM model, K = 6. Per-word cost is 14 cycles.
- Timeout abort: enable falls at edge s'+TIMEOUT, where s' is the entry edge into RD/WR.

## Test plan
- Copy: src=0x100, dst=0x200, count=3, responder K=3, memory 0x100..0x108 = A,B,C.
  - 0x200..0x208 = A,B,C.
  - o_done is high exactly one cycle, after 24 cycles.
  - Bus trace: R,W,R,W,R,W with one low-enable cycle between each.
- count=0: o_done pulses the cycle after start, o_bus_enable never rises, o_error = 0.
- Unaligned/wrap: src=0x103, dst=0xFFFF_FFFC, count=2.
  - Addresses issued: 0x100, 0xFFFF_FFFC, 0x104, 0x0000_0000.
- Timeout: TIMEOUT=10, responder never readies.
  - Enable falls 10 cycles after rising.
  - o_error = 1, o_done pulse, busy = 0.
  - The next start clears o_error.
- Reset mid-write (after the second read completes): all outputs are 0 the cycle after reset. A following start=1, count=1 completes normally.
- i_start pulsed during busy: ignored. Copy count and o_done timing are unchanged, and there is exactly one o_done.

Source files
------------

// File: rtl/bus_copy_master.sv
// bus_copy_master
// Word-copy DMA initiator for the enable/rw/ready memory bus. For each of
// i_count words it reads the source word, then writes it to the destination.
// Every access is one bus transaction followed by one cycle with enable low.
//
// Ports
//   i_clock        single clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_start        start pulse, only sampled while idle
//   i_src, i_dst   source / destination byte addresses (bits [1:0] ignored)
//   i_count        number of 32-bit words to copy
//   o_busy         high from the accepting edge until completion
//   o_done         one-cycle pulse at completion or timeout abort
//   o_error        set by a timeout abort, cleared by the next accepted start
//   o_bus_enable   request active
//   o_bus_rw       0 = read, 1 = write
//   o_bus_address  word-aligned byte address
//   o_bus_wdata    write data
//   i_bus_rdata    read data, valid while i_bus_ready is high on a read
//   i_bus_ready    responder completion, held until enable drops
module bus_copy_master #(
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [31:0]            i_src,
   input  logic [31:0]            i_dst,
   input  logic [COUNT_WIDTH-1:0] i_count,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic                   o_bus_enable,
   output logic                   o_bus_rw,
   output logic [31:0]            o_bus_address,
   output logic [31:0]            o_bus_wdata,
   input  logic [31:0]            i_bus_rdata,
   input  logic                   i_bus_ready
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RD_GAP = 3'd2,
      ST_WR     = 3'd3,
      ST_WR_GAP = 3'd4
   } state_t;

   // The wait counter only has to hold values up to TIMEOUT-1.
   localparam int unsigned TO_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);
   localparam logic [TO_W-1:0] TO_ONE = TO_W'(32'd1);
   localparam logic [COUNT_WIDTH-1:0] REM_ONE = COUNT_WIDTH'(32'd1);
   localparam logic TO_ENABLED = (TIMEOUT != 32'd0);

   state_t                 state_r, state_s;
   logic [31:0]            src_r, src_s;
   logic [31:0]            dst_r, dst_s;
   logic [COUNT_WIDTH-1:0] rem_r, rem_s;
   logic [31:0]            data_r, data_s;
   logic [TO_W-1:0]        to_r, to_s;
   logic                   busy_s, done_s, error_s, enable_s, rw_s;
   logic [31:0]            address_s, wdata_s;
   logic                   to_hit_s;

   // Abort fires on the edge that would make the wait count reach TIMEOUT.
   assign to_hit_s = TO_ENABLED && (to_r == TO_LAST);

   // Next-state and next-output computation for every register.
   always_comb begin
      state_s   = state_r;
      src_s     = src_r;
      dst_s     = dst_r;
      rem_s     = rem_r;
      data_s    = data_r;
      to_s      = to_r;
      busy_s    = o_busy;
      done_s    = 1'b0;
      error_s   = o_error;
      enable_s  = o_bus_enable;
      rw_s      = o_bus_rw;
      address_s = o_bus_address;
      wdata_s   = o_bus_wdata;

      case (state_r)
         ST_IDLE: begin
            enable_s = 1'b0;
            if (i_start) begin
               src_s   = i_src & 32'hFFFF_FFFC;
               dst_s   = i_dst & 32'hFFFF_FFFC;
               rem_s   = i_count;
               error_s = 1'b0;
               if (i_count == '0) begin
                  done_s = 1'b1;
                  busy_s = 1'b0;
               end else begin
                  busy_s    = 1'b1;
                  enable_s  = 1'b1;
                  rw_s      = 1'b0;
                  address_s = i_src & 32'hFFFF_FFFC;
                  to_s      = '0;
                  state_s   = ST_RD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_RD: begin
            if (i_bus_ready) begin
               data_s   = i_bus_rdata;
               enable_s = 1'b0;
               state_s  = ST_RD_GAP;
            end else if (to_hit_s) begin
               enable_s = 1'b0;
               error_s  = 1'b1;
               done_s   = 1'b1;
               busy_s   = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               to_s = to_r + TO_ONE;
            end
         end

         ST_RD_GAP: begin
            enable_s  = 1'b1;
            rw_s      = 1'b1;
            address_s = dst_r;
            wdata_s   = data_r;
            to_s      = '0;
            state_s   = ST_WR;
         end

         ST_WR: begin
            if (i_bus_ready) begin
               enable_s = 1'b0;
               rem_s    = rem_r - REM_ONE;
               src_s    = src_r + 32'd4;
               dst_s    = dst_r + 32'd4;
               state_s  = ST_WR_GAP;
            end else if (to_hit_s) begin
               enable_s = 1'b0;
               error_s  = 1'b1;
               done_s   = 1'b1;
               busy_s   = 1'b0;
               state_s  = ST_IDLE;
            end else begin
               to_s = to_r + TO_ONE;
            end
         end

         ST_WR_GAP: begin
            // rem_r was already decremented by the completing write.
            if (rem_r == '0) begin
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               enable_s  = 1'b1;
               rw_s      = 1'b0;
               address_s = src_r;
               to_s      = '0;
               state_s   = ST_RD;
            end
         end

         default: begin
            enable_s = 1'b0;
            busy_s   = 1'b0;
            state_s  = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; reset overrides any transfer.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r       <= ST_IDLE;
         src_r         <= 32'd0;
         dst_r         <= 32'd0;
         rem_r         <= '0;
         data_r        <= 32'd0;
         to_r          <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
         o_bus_enable  <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= 32'd0;
         o_bus_wdata   <= 32'd0;
      end else begin
         state_r       <= state_s;
         src_r         <= src_s;
         dst_r         <= dst_s;
         rem_r         <= rem_s;
         data_r        <= data_s;
         to_r          <= to_s;
         o_busy        <= busy_s;
         o_done        <= done_s;
         o_error       <= error_s;
         o_bus_enable  <= enable_s;
         o_bus_rw      <= rw_s;
         o_bus_address <= address_s;
         o_bus_wdata   <= wdata_s;
      end
   end

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: a wait-state responder with a
// sparse memory, a reference copy model feeding a scoreboard of expected bus
// transactions and completions, and a monitor that checks them as they occur.
module tb_bus_copy_master;

   localparam int TO = 10;

   logic        clk = 1'b0;
   logic        i_reset, i_start;
   logic [31:0] i_src, i_dst;
   logic [15:0] i_count;
   logic        o_busy, o_done, o_error, o_bus_enable, o_bus_rw;
   logic [31:0] o_bus_address, o_bus_wdata, i_bus_rdata;
   logic        i_bus_ready;

   bus_copy_master #(.TIMEOUT(TO), .COUNT_WIDTH(16)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
      .i_src(i_src), .i_dst(i_dst), .i_count(i_count),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_bus_enable(o_bus_enable), .o_bus_rw(o_bus_rw),
      .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
      .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_t;
   typedef struct packed {
      logic        err;
      logic [31:0] cyc;
   } done_t;

   bus_t  exp_bus[$];
   done_t exp_done[$];

   logic [31:0] mem   [logic [31:0]];
   logic [31:0] model [logic [31:0]];

   int checks = 0;
   int failures = 0;
   int rises = 0;
   int done_events = 0;
   int start_cyc = 0;
   int resp_wait = 0;
   bit resp_hang = 1'b0;
   bit mon_on = 1'b0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      else return 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Responder: raises ready after resp_wait cycles of enable, K = resp_wait+1.
   int wcnt = 0;
   always @(negedge clk) begin
      if (o_bus_enable !== 1'b1) begin
         wcnt = 0;
         i_bus_ready = 1'b0;
      end else if (!i_bus_ready && !resp_hang) begin
         if (wcnt == resp_wait) begin
            i_bus_ready = 1'b1;
            if (o_bus_rw) mem[o_bus_address] = o_bus_wdata;
            else i_bus_rdata = mem_rd(o_bus_address);
         end else begin
            wcnt++;
         end
      end
   end

   // Monitor: checks each new transaction and each done pulse against the scoreboard.
   logic prev_en = 1'b0;
   logic busy_prev = 1'b0;
   int   fall_cyc = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         if (o_bus_enable === 1'b1 && prev_en !== 1'b1) begin
            bus_t e;
            rises++;
            chk("busy_during_txn", 32'(o_busy), 32'd1);
            if (busy_prev === 1'b1) chk("gap_cycles", 32'(cyc - fall_cyc), 32'd1);
            if (exp_bus.size() == 0) begin
               chk("unexpected_txn_addr", o_bus_address, 32'hDEAD_BEEF);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_rw", 32'(o_bus_rw), 32'(e.rw));
               chk("bus_addr", o_bus_address, e.addr);
               if (e.rw) chk("bus_wdata", o_bus_wdata, e.data);
            end
         end
         if (o_bus_enable === 1'b0 && prev_en === 1'b1) fall_cyc = cyc;
         if (o_done === 1'b1) begin
            done_t d;
            done_events++;
            if (exp_done.size() == 0) begin
               chk("unexpected_done_cycle", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               d = exp_done.pop_front();
               chk("done_error", 32'(o_error), 32'(d.err));
               chk("done_cycle", 32'(cyc), d.cyc);
               chk("done_busy", 32'(o_busy), 32'd0);
            end
         end
         prev_en   = o_bus_enable;
         busy_prev = o_busy;
      end
   end

   // Reference model: copies word by word in order, producing expected traffic.
   task automatic launch(input logic [31:0] src, input logic [31:0] dst,
                         input int cnt, input int wt, input bit hang);
      logic [31:0] sa, da, a, d;
      sa = src & 32'hFFFF_FFFC;
      da = dst & 32'hFFFF_FFFC;
      resp_wait = wt;
      resp_hang = hang;
      for (int i = 0; i < cnt; i++) begin
         a = sa + 32'(4 * i);
         if (!mem.exists(a)) mem[a] = $urandom;
         model[a] = mem[a];
      end
      for (int i = 0; i < cnt; i++) begin
         a = sa + 32'(4 * i);
         d = model[a];
         exp_bus.push_back('{1'b0, a, 32'h0});
         if (hang) break;
         exp_bus.push_back('{1'b1, da + 32'(4 * i), d});
         model[da + 32'(4 * i)] = d;
      end
      start_cyc = cyc;
      if (hang) exp_done.push_back('{1'b1, 32'(start_cyc + 1 + TO)});
      else exp_done.push_back('{1'b0, 32'(start_cyc + 1 + 2 * cnt * (wt + 2))});
      i_src = src;
      i_dst = dst;
      i_count = 16'(cnt);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_events == d0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_events == d0) chk({name, "_done_timeout"}, 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input logic [31:0] dst, input int cnt, input string name);
      logic [31:0] a;
      for (int i = 0; i < cnt; i++) begin
         a = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
         chk({name, "_mem"}, mem_rd(a), model[a]);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 32'(o_busy), 32'd0);
      chk({name, "_done"}, 32'(o_done), 32'd0);
      chk({name, "_error"}, 32'(o_error), 32'd0);
      chk({name, "_enable"}, 32'(o_bus_enable), 32'd0);
      chk({name, "_rw"}, 32'(o_bus_rw), 32'd0);
      chk({name, "_addr"}, o_bus_address, 32'd0);
      chk({name, "_wdata"}, o_bus_wdata, 32'd0);
   endtask

   initial begin
      int d0, r0, n, dd;
      i_reset = 1'b1; i_start = 1'b0; i_src = 32'd0; i_dst = 32'd0;
      i_count = 16'd0; i_bus_rdata = 32'd0; i_bus_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      i_reset = 1'b0;
      mon_on = 1'b1;
      @(posedge clk); #1;

      // Basic three-word copy, K = 3 -> done 24 cycles after start edge.
      mem[32'h100] = 32'hAAAA_0001;
      mem[32'h104] = 32'hBBBB_0002;
      mem[32'h108] = 32'hCCCC_0003;
      d0 = done_events;
      launch(32'h100, 32'h200, 3, 2, 1'b0);
      wait_done(d0, "copy3");
      chk("copy3_w0", mem_rd(32'h200), 32'hAAAA_0001);
      chk("copy3_w1", mem_rd(32'h204), 32'hBBBB_0002);
      chk("copy3_w2", mem_rd(32'h208), 32'hCCCC_0003);

      // Zero-length copy: done the cycle after start, no bus activity.
      d0 = done_events; r0 = rises;
      launch(32'h300, 32'h400, 0, 1, 1'b0);
      wait_done(d0, "count0");
      chk("count0_no_bus", 32'(rises - r0), 32'd0);
      chk("count0_error", 32'(o_error), 32'd0);

      // Unaligned source and wrapping destination.
      d0 = done_events;
      launch(32'h103, 32'hFFFF_FFFC, 2, 1, 1'b0);
      wait_done(d0, "wrap");
      check_mem(32'hFFFF_FFFC, 2, "wrap");

      // Randomized copies.
      for (int j = 0; j < 8; j++) begin
         logic [31:0] s, t;
         int c;
         s = $urandom; t = $urandom; c = $urandom_range(0, 5);
         d0 = done_events;
         launch(s, t, c, $urandom_range(0, 6), 1'b0);
         wait_done(d0, "rand");
         check_mem(t, c, "rand");
      end

      // Timeout: responder never readies.
      d0 = done_events;
      launch(32'h400, 32'h500, 2, 0, 1'b1);
      wait_done(d0, "timeout");
      chk("timeout_error", 32'(o_error), 32'd1);
      chk("timeout_busy", 32'(o_busy), 32'd0);
      d0 = done_events;
      launch(32'h600, 32'h700, 1, 1, 1'b0);
      chk("restart_clears_error", 32'(o_error), 32'd0);
      wait_done(d0, "after_timeout");
      check_mem(32'h700, 1, "after_timeout");

      // Reset during the second write.
      r0 = rises; n = 0;
      launch(32'h800, 32'h900, 3, 4, 1'b0);
      while (rises < r0 + 4 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reset_mid_reached_wr2", 32'(rises - r0 >= 4), 32'd1);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      exp_bus.delete();
      exp_done.delete();
      chk_all_zero("reset_mid");
      @(posedge clk); #1;
      d0 = done_events;
      launch(32'hA00, 32'hB00, 1, 1, 1'b0);
      wait_done(d0, "after_reset");
      check_mem(32'hB00, 1, "after_reset");

      // Start pulses while busy, including one on the completion edge.
      d0 = done_events; n = 0;
      launch(32'hC00, 32'hD00, 2, 2, 1'b0);
      dd = 2 * 2 * (2 + 2);
      while (done_events == d0 && n < 500) begin
         if (cyc == start_cyc + 5) begin
            i_start = 1'b1; i_src = 32'h1234; i_count = 16'd7;
         end else if (cyc == start_cyc + dd) begin
            i_start = 1'b1; i_src = 32'hE00; i_count = 16'd1;
         end else begin
            i_start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      i_start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("busy_start_one_done", 32'(done_events - d0), 32'd1);
      check_mem(32'hD00, 2, "busy_start");

      chk("leftover_bus", 32'(exp_bus.size()), 32'd0);
      chk("leftover_done", 32'(exp_done.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
